// File: rtl/rh_temp_meas_sched_pkg.sv
// rtl/rh_temp_meas_sched_pkg.sv - shared constants for the RH/temp measurement scheduler
package rh_temp_pkg;

  localparam int AVL_AW = 3;
  localparam int AVL_DW = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_TRIG = 3'd1;
  localparam state_t ST_WAIT = 3'd2;
  localparam state_t ST_READ = 3'd3;
  localparam state_t ST_ERR  = 3'd4;

  localparam logic [AVL_AW-1:0] ADDR_CTRL    = 3'd0;
  localparam logic [AVL_AW-1:0] ADDR_PERIOD  = 3'd1;
  localparam logic [AVL_AW-1:0] ADDR_STATUS  = 3'd2;
  localparam logic [AVL_AW-1:0] ADDR_DATA    = 3'd3;
  localparam logic [AVL_AW-1:0] ADDR_TIMEOUT = 3'd4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_START  = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_TMO  = 2;
  localparam int STAT_NACK = 3;

endpackage

// File: rtl/rh_temp_meas_sched_if.sv
// rtl/rh_temp_meas_sched_if.sv - Avalon-MM register bus plus I2C master command port
interface rh_temp_meas_sched_if;
  import rh_temp_pkg::*;

  logic [AVL_AW-1:0] address;
  logic              write;
  logic [AVL_DW-1:0] writedata;
  logic [AVL_DW-1:0] readdata;
  logic              irq;
  logic              trig_req;
  logic              trig_ack;
  logic              rd_req;
  logic              rd_ack;
  logic [31:0]       rd_data;
  logic              i2c_err;

  modport slave (
    input  address, write, writedata, trig_ack, rd_ack, rd_data, i2c_err,
    output readdata, irq, trig_req, rd_req
  );

  modport master (
    output address, write, writedata, trig_ack, rd_ack, rd_data, i2c_err,
    input  readdata, irq, trig_req, rd_req
  );

endinterface

// File: rtl/rh_temp_meas_sched_drdy_sync_edge.sv
// rtl/rh_temp_meas_sched_drdy_sync_edge.sv - synchronizer and falling-edge pulse for an active-low ready line
module drdy_sync_edge #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din_n,
  output logic fall
);

  logic [SYNC_STG-1:0] sync;
  logic                last;

  // Shift the pin through the chain; idle level is high so reset to 1 avoids a false edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '1;
      last <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STG-2:0], din_n};
      last <= sync[SYNC_STG-1];
    end
  end

  assign fall = last & ~sync[SYNC_STG-1];

endmodule

// File: rtl/rh_temp_meas_sched.sv
// rtl/rh_temp_meas_sched.sv - periodic RH/temp conversion scheduler with register file and IRQ
module rh_temp_meas_sched
  import rh_temp_pkg::*;
#(
  parameter int               CNT_W      = 32,
  parameter int               SYNC_STG   = 2,
  parameter logic [CNT_W-1:0] PERIOD_RST = CNT_W'(50_000_000),
  parameter logic [CNT_W-1:0] TMO_RST    = CNT_W'(2_500_000)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               drdy_n,
  rh_temp_meas_sched_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  pcnt;
  logic [CNT_W-1:0]  tcnt;
  logic [CNT_W-1:0]  period;
  logic [CNT_W-1:0]  timeout;
  logic [CNT_W-1:0]  tmo_last;
  logic              en;
  logic              irq_en;
  logic              done;
  logic              tmo;
  logic              nack;
  logic [31:0]       data;
  logic [AVL_DW-1:0] readdata_q;
  logic              busy;
  logic              drdy_fall;
  logic              start_req;
  logic              status_wr;
  logic              period_hit;
  logic              set_done;
  logic              set_tmo;
  logic              set_nack;

  drdy_sync_edge #(
    .SYNC_STG(SYNC_STG)
  ) u_drdy_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .din_n  (drdy_n),
    .fall   (drdy_fall)
  );

  assign busy      = (state != ST_IDLE);
  assign start_req = bus.write && (bus.address == ADDR_CTRL) && bus.writedata[CTRL_START];
  assign status_wr = bus.write && (bus.address == ADDR_STATUS);

  // PERIOD of 0 or 1 fires on the first IDLE cycle; TIMEOUT of 0 behaves as 1
  assign period_hit = (period < CNT_W'(2)) || (pcnt == period - CNT_W'(1));
  assign tmo_last   = (timeout == '0) ? '0 : timeout - CNT_W'(1);

  // Next-state decode; errors take priority over acks, data-ready over timeout
  always_comb begin
    state_nxt = state;
    set_done  = 1'b0;
    set_tmo   = 1'b0;
    set_nack  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_req || (en && period_hit)) state_nxt = ST_TRIG;
      end
      ST_TRIG: begin
        if (bus.i2c_err) begin
          state_nxt = ST_ERR;
          set_nack  = 1'b1;
        end else if (bus.trig_ack) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (drdy_fall) begin
          state_nxt = ST_READ;
        end else if (tcnt == tmo_last) begin
          state_nxt = ST_ERR;
          set_tmo   = 1'b1;
        end
      end
      ST_READ: begin
        if (bus.i2c_err) begin
          state_nxt = ST_ERR;
          set_nack  = 1'b1;
        end else if (bus.rd_ack) begin
          state_nxt = ST_IDLE;
          set_done  = 1'b1;
        end
      end
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Period counter runs only while enabled and staying in IDLE; timeout counter only in WAIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
      tcnt <= '0;
    end else begin
      if (state == ST_IDLE && state_nxt == ST_IDLE && en) pcnt <= pcnt + CNT_W'(1);
      else                                                pcnt <= '0;
      if (state == ST_WAIT) tcnt <= tcnt + CNT_W'(1);
      else                  tcnt <= '0;
    end
  end

  // Software-writable configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      period  <= PERIOD_RST;
      timeout <= TMO_RST;
    end else if (bus.write) begin
      case (bus.address)
        ADDR_CTRL: begin
          en     <= bus.writedata[CTRL_EN];
          irq_en <= bus.writedata[CTRL_IRQ_EN];
        end
        ADDR_PERIOD:  period  <= CNT_W'(bus.writedata);
        ADDR_TIMEOUT: timeout <= CNT_W'(bus.writedata);
        default: ;
      endcase
    end
  end

  // Sticky status flags: a hardware set in the same cycle as a W1C keeps the flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b0;
      tmo  <= 1'b0;
      nack <= 1'b0;
    end else begin
      done <= set_done | (done & ~(status_wr & bus.writedata[STAT_DONE]));
      tmo  <= set_tmo  | (tmo  & ~(status_wr & bus.writedata[STAT_TMO]));
      nack <= set_nack | (nack & ~(status_wr & bus.writedata[STAT_NACK]));
    end
  end

  // Result capture on a clean read completion only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      data <= '0;
    else if (set_done) data <= bus.rd_data;
  end

  // Registered read mux, refreshed every cycle from the current address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      case (bus.address)
        ADDR_CTRL:    readdata_q <= 32'({irq_en, en});
        ADDR_PERIOD:  readdata_q <= 32'(period);
        ADDR_STATUS:  readdata_q <= {28'd0, nack, tmo, done, busy};
        ADDR_DATA:    readdata_q <= data;
        ADDR_TIMEOUT: readdata_q <= 32'(timeout);
        default:      readdata_q <= '0;
      endcase
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = done & irq_en;
  assign bus.trig_req = (state == ST_TRIG);
  assign bus.rd_req   = (state == ST_READ);

endmodule

// File: tb/tb_rh_temp_meas_sched.sv
// tb/tb_rh_temp_meas_sched.sv - directed self-checking bench for rh_temp_meas_sched
module tb_rh_temp_meas_sched;
  import rh_temp_pkg::*;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        drdy_n  = 1'b1;
  int          tests   = 0;
  int          fails   = 0;
  int unsigned cyc     = 0;
  int unsigned t0;
  int unsigned t1;
  int          extra;
  logic [31:0] v;

  rh_temp_meas_sched_if bus();

  rh_temp_meas_sched dut (
    .clk    (clk),
    .reset_n(reset_n),
    .drdy_n (drdy_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    tick();
    bus.write     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.address = a;
    tick();
    d = bus.readdata;
  endtask

  task automatic wait_hi(input bit use_rd, input int bound, input string tag);
    int n = 0;
    while (((use_rd ? bus.rd_req : bus.trig_req) !== 1'b1) && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 32'(use_rd ? bus.rd_req : bus.trig_req), 32'd1);
  endtask

  task automatic serve(input logic [31:0] d);
    bus.trig_ack = 1'b1;
    tick();
    bus.trig_ack = 1'b0;
    drdy_n = 1'b0;
    wait_hi(1'b1, 10, "serve_rd_req");
    bus.rd_data = d;
    bus.rd_ack  = 1'b1;
    tick();
    bus.rd_ack  = 1'b0;
    drdy_n = 1'b1;
  endtask

  initial begin
    bus.address   = '0;
    bus.write     = 1'b0;
    bus.writedata = '0;
    bus.trig_ack  = 1'b0;
    bus.rd_ack    = 1'b0;
    bus.rd_data   = '0;
    bus.i2c_err   = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_readdata", bus.readdata, 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_trig_req", 32'(bus.trig_req), 32'd0);
    chk("rst_rd_req", 32'(bus.rd_req), 32'd0);
    reset_n = 1'b1;
    rd(ADDR_PERIOD, v);  chk("rst_period", v, 32'd50000000);
    rd(ADDR_TIMEOUT, v); chk("rst_timeout", v, 32'd2500000);
    rd(ADDR_STATUS, v);  chk("rst_status", v, 32'd0);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, v);         chk("unmapped_reads_0", v, 32'd0);

    // one-shot conversion
    wr(ADDR_CTRL, 32'h4);
    chk("t1_trig_req", 32'(bus.trig_req), 32'd1);
    tick();
    tick();
    bus.trig_ack = 1'b1;
    tick();
    bus.trig_ack = 1'b0;
    repeat (100) tick();
    drdy_n = 1'b0;
    tick();
    tick();
    chk("t1_drdy_early", 32'(bus.rd_req), 32'd0);
    tick();
    chk("t1_drdy_latency", 32'(bus.rd_req), 32'd1);
    drdy_n = 1'b1;
    bus.rd_data = 32'h6A3C_8F00;
    bus.rd_ack  = 1'b1;
    tick();
    bus.rd_ack  = 1'b0;
    chk("t1_rd_req_drop", 32'(bus.rd_req), 32'd0);
    rd(ADDR_STATUS, v); chk("t1_status", v, 32'h2);
    rd(ADDR_DATA, v);   chk("t1_data", v, 32'h6A3C_8F00);
    chk("t1_irq", 32'(bus.irq), 32'd0);
    rd(ADDR_CTRL, v);   chk("t1_ctrl_start_reads_0", v, 32'd0);

    // periodic operation
    wr(ADDR_STATUS, 32'hE);
    wr(ADDR_PERIOD, 32'd20);
    wr(ADDR_CTRL, 32'h3);
    t0 = cyc;
    wait_hi(1'b0, 40, "t2_trig1");
    chk("t2_first_period", cyc - t0, 32'd20);
    t1 = cyc;
    serve(32'h1111_2222);
    chk("t2_irq_set", 32'(bus.irq), 32'd1);
    wr(ADDR_STATUS, 32'h2);
    chk("t2_irq_clr", 32'(bus.irq), 32'd0);
    wait_hi(1'b0, 40, "t2_trig2");
    chk("t2_repeat_period", cyc - t1, 32'd25);

    // en cleared mid-transaction: finish, then stay idle
    wr(ADDR_CTRL, 32'h0);
    chk("t2_trig_held", 32'(bus.trig_req), 32'd1);
    serve(32'h3333_4444);
    extra = 0;
    repeat (40) begin
      tick();
      if (bus.trig_req === 1'b1) extra++;
    end
    chk("t2_en_off_idle", 32'(extra), 32'd0);
    rd(ADDR_DATA, v); chk("t2_data", v, 32'h3333_4444);

    // PERIOD=0 fires on the first enabled IDLE cycle
    wr(ADDR_STATUS, 32'hF);
    wr(ADDR_PERIOD, 32'd0);
    wr(ADDR_CTRL, 32'h1);
    chk("p0_not_yet", 32'(bus.trig_req), 32'd0);
    tick();
    chk("p0_first_idle", 32'(bus.trig_req), 32'd1);
    wr(ADDR_CTRL, 32'h0);
    serve(32'h5555_6666);

    // timeout
    wr(ADDR_STATUS, 32'hF);
    wr(ADDR_TIMEOUT, 32'd50);
    wr(ADDR_CTRL, 32'h4);
    bus.trig_ack = 1'b1;
    tick();
    bus.trig_ack = 1'b0;
    t0 = cyc;
    bus.address = ADDR_STATUS;
    while (bus.readdata[STAT_TMO] !== 1'b1 && (cyc - t0) < 100) tick();
    chk("t3_tmo_latency", cyc - t0, 32'd51);
    chk("t3_status_err", bus.readdata, 32'h5);
    tick();
    chk("t3_status_idle", bus.readdata, 32'h4);
    rd(ADDR_DATA, v); chk("t3_data_kept", v, 32'h5555_6666);

    // TIMEOUT=0 acts as 1
    wr(ADDR_STATUS, 32'hF);
    wr(ADDR_TIMEOUT, 32'd0);
    wr(ADDR_CTRL, 32'h4);
    bus.trig_ack = 1'b1;
    tick();
    bus.trig_ack = 1'b0;
    bus.address = ADDR_STATUS;
    tick();
    tick();
    chk("tmo0_as_1", bus.readdata, 32'h5);

    // NACK during READ, with rd_ack in the same cycle
    wr(ADDR_STATUS, 32'hF);
    wr(ADDR_TIMEOUT, 32'd1000);
    wr(ADDR_CTRL, 32'h4);
    bus.trig_ack = 1'b1;
    tick();
    bus.trig_ack = 1'b0;
    drdy_n = 1'b0;
    wait_hi(1'b1, 10, "t4_rd_req");
    bus.rd_data = 32'hDEAD_BEEF;
    bus.rd_ack  = 1'b1;
    bus.i2c_err = 1'b1;
    tick();
    bus.rd_ack  = 1'b0;
    bus.i2c_err = 1'b0;
    drdy_n = 1'b1;
    chk("t4_rd_req_drop", 32'(bus.rd_req), 32'd0);
    tick();
    rd(ADDR_STATUS, v); chk("t4_status_nack", v, 32'h8);
    rd(ADDR_DATA, v);   chk("t4_data_kept", v, 32'h5555_6666);

    // drdy_fall and timeout in the same cycle
    wr(ADDR_STATUS, 32'hF);
    wr(ADDR_TIMEOUT, 32'd10);
    wr(ADDR_CTRL, 32'h4);
    bus.trig_ack = 1'b1;
    tick();
    bus.trig_ack = 1'b0;
    repeat (7) tick();
    drdy_n = 1'b0;
    tick();
    tick();
    tick();
    chk("t5_race_read", 32'(bus.rd_req), 32'd1);
    drdy_n = 1'b1;
    bus.rd_data = 32'h7777_8888;
    bus.rd_ack  = 1'b1;
    tick();
    bus.rd_ack  = 1'b0;
    rd(ADDR_STATUS, v); chk("t5_race_status", v, 32'h2);

    // W1C of done in the same cycle as rd_ack
    wr(ADDR_STATUS, 32'hF);
    wr(ADDR_CTRL, 32'h4);
    bus.trig_ack = 1'b1;
    tick();
    bus.trig_ack = 1'b0;
    drdy_n = 1'b0;
    wait_hi(1'b1, 10, "t5_w1c_rd_req");
    bus.rd_data   = 32'h9999_AAAA;
    bus.rd_ack    = 1'b1;
    bus.address   = ADDR_STATUS;
    bus.writedata = 32'h2;
    bus.write     = 1'b1;
    tick();
    bus.write     = 1'b0;
    bus.rd_ack    = 1'b0;
    drdy_n = 1'b1;
    rd(ADDR_STATUS, v); chk("t5_w1c_set_wins", v, 32'h2);
    rd(ADDR_DATA, v);   chk("t5_w1c_data", v, 32'h9999_AAAA);

    // start written while busy is ignored
    wr(ADDR_CTRL, 32'h4);
    wr(ADDR_CTRL, 32'h4);
    serve(32'hBBBB_CCCC);
    extra = 0;
    repeat (30) begin
      tick();
      if (bus.trig_req === 1'b1) extra++;
    end
    chk("t5_start_busy_ignored", 32'(extra), 32'd0);

    // reset mid-WAIT
    wr(ADDR_CTRL, 32'h6);
    bus.trig_ack = 1'b1;
    tick();
    bus.trig_ack = 1'b0;
    tick();
    chk("t6_irq_pre", 32'(bus.irq), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_async_irq", 32'(bus.irq), 32'd0);
    chk("t6_async_trig", 32'(bus.trig_req), 32'd0);
    chk("t6_async_rd", 32'(bus.rd_req), 32'd0);
    chk("t6_async_readdata", bus.readdata, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    rd(ADDR_CTRL, v);    chk("t6_ctrl", v, 32'd0);
    rd(ADDR_PERIOD, v);  chk("t6_period", v, 32'd50000000);
    rd(ADDR_TIMEOUT, v); chk("t6_timeout", v, 32'd2500000);
    rd(ADDR_DATA, v);    chk("t6_data", v, 32'd0);
    repeat (10) tick();
    rd(ADDR_STATUS, v);  chk("t6_status_idle", v, 32'd0);
    chk("t6_no_trig", 32'(bus.trig_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
